wb_rr_arbiter: RTL and testbench

Round-robin Wishbone (classic, registered-grant) arbiter that shares one Wishbone slave port among `N_MASTER` requesters. It sits between core/debug masters and a single-ported slave such as a `wb_ram_wrapper`, where a full `wb_xbar` is oversized. It also carries a per-transfer watchdog that terminates hung slave cycles with `err`.

---
 rtl/wb_arb_pkg.sv | 18 +
 rtl/rr_prio_enc.sv | 33 +++
 rtl/wb_rr_arbiter.sv | 137 +++++++++++++
 tb/tb_wb_rr_arbiter.sv | 422 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_arb_pkg.sv
// Shared types and helpers for the Wishbone round-robin arbiter.
package wb_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    // Width of the watchdog counter; never narrower than one bit so that a
    // disabled watchdog (timeout 0) still yields a legal vector.
    function automatic int wd_width(input int timeout);
        int w;
        w = $clog2(timeout + 1);
        if (w < 1) w = 1;
        return w;
    endfunction

endpackage

// File: rtl/rr_prio_enc.sv
// Combinational round-robin priority encoder: grants the first requester
// found searching upward (modulo N) from the position after the one-hot 'last'.
module rr_prio_enc #(
    parameter int N = 4
) (
    input  logic [N-1:0] req,
    input  logic [N-1:0] last,
    output logic [N-1:0] gnt,
    output logic         valid
);

    int last_idx;
    int idx;

    // Locate the previous winner, then scan the ring starting just after it.
    always_comb begin
        gnt      = '0;
        valid    = 1'b0;
        last_idx = N - 1;
        idx      = 0;
        for (int i = 0; i < N; i++) begin
            if (last[i]) last_idx = i;
        end
        for (int k = 1; k <= N; k++) begin
            idx = (last_idx + k) % N;
            if (!valid && req[idx]) begin
                gnt[idx] = 1'b1;
                valid    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wb_rr_arbiter.sv
// Round-robin arbiter sharing one Wishbone classic slave among N_MASTER
// masters, with a per-transfer watchdog that ends hung cycles with err.
// Handshake: a transfer is live while the granted master holds cyc and stb;
// it completes in the cycle the slave raises ack/err (forwarded
// combinationally) or the watchdog fires. Only the granted master is served.
module wb_rr_arbiter
    import wb_arb_pkg::*;
#(
    parameter int N_MASTER  = 4,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int TIMEOUT   = 255,
    localparam int SEL_W    = DATA_W / 8
) (
    input  logic                       clk,
    input  logic                       rstn_i,
    input  logic [N_MASTER-1:0]        m_cyc_i,
    input  logic [N_MASTER-1:0]        m_stb_i,
    input  logic [N_MASTER-1:0]        m_we_i,
    input  logic [N_MASTER*ADDR_W-1:0] m_adr_i,
    input  logic [N_MASTER*DATA_W-1:0] m_dat_i,
    input  logic [N_MASTER*SEL_W-1:0]  m_sel_i,
    output logic [DATA_W-1:0]          m_dat_o,
    output logic [N_MASTER-1:0]        m_ack_o,
    output logic [N_MASTER-1:0]        m_err_o,
    output logic                       s_cyc_o,
    output logic                       s_stb_o,
    output logic                       s_we_o,
    output logic [ADDR_W-1:0]          s_adr_o,
    output logic [DATA_W-1:0]          s_dat_o,
    output logic [SEL_W-1:0]           s_sel_o,
    input  logic [DATA_W-1:0]          s_dat_i,
    input  logic                       s_ack_i,
    input  logic                       s_err_i,
    output logic [N_MASTER-1:0]        grant_o,
    output logic                       dbg_state
);

    localparam int              WD_W     = wd_width(TIMEOUT);
    localparam logic [WD_W-1:0] WD_MAX   = WD_W'(TIMEOUT);
    localparam bit              WD_EN    = (TIMEOUT != 0);
    localparam logic [N_MASTER-1:0] LAST_RST = {1'b1, {(N_MASTER-1){1'b0}}};

    arb_state_t          state, state_nxt;
    logic [N_MASTER-1:0] last, last_nxt, grant_nxt;
    logic [N_MASTER-1:0] enc_gnt;
    logic                enc_valid;
    logic [WD_W-1:0]     wd_cnt, wd_cnt_nxt;
    logic                wd_err;
    logic                owner_cyc;
    logic                stb_raw;

    rr_prio_enc #(.N(N_MASTER)) u_enc (
        .req   (m_cyc_i),
        .last  (last),
        .gnt   (enc_gnt),
        .valid (enc_valid)
    );

    // Grant-indexed mux of master signals onto the slave port; zero when idle.
    always_comb begin
        owner_cyc = 1'b0;
        stb_raw   = 1'b0;
        s_we_o    = 1'b0;
        s_adr_o   = '0;
        s_dat_o   = '0;
        s_sel_o   = '0;
        for (int i = 0; i < N_MASTER; i++) begin
            if (grant_o[i]) begin
                owner_cyc = m_cyc_i[i];
                stb_raw   = m_stb_i[i];
                s_we_o    = m_we_i[i];
                s_adr_o   = m_adr_i[i*ADDR_W +: ADDR_W];
                s_dat_o   = m_dat_i[i*DATA_W +: DATA_W];
                s_sel_o   = m_sel_i[i*SEL_W +: SEL_W];
            end
        end
    end

    // Expiry fires only when the slave is silent; a same-cycle ack/err wins.
    assign wd_err  = WD_EN && (wd_cnt == WD_MAX) && stb_raw && !s_ack_i && !s_err_i;
    assign s_cyc_o = owner_cyc;
    assign s_stb_o = stb_raw & ~wd_err;

    assign m_dat_o   = s_dat_i;
    assign m_ack_o   = grant_o & {N_MASTER{s_ack_i}};
    assign m_err_o   = grant_o & {N_MASTER{s_err_i | wd_err}};
    assign dbg_state = (state == GRANT);

    // Watchdog counts stalled strobe cycles and restarts on any completion.
    always_comb begin
        wd_cnt_nxt = '0;
        if (WD_EN && s_stb_o && !s_ack_i && !s_err_i) wd_cnt_nxt = wd_cnt + 1'b1;
    end

    // Next-state logic: arbitrate from IDLE, hold the grant while cyc stays up.
    always_comb begin
        state_nxt = state;
        grant_nxt = grant_o;
        last_nxt  = last;
        case (state)
            IDLE: begin
                if (enc_valid) begin
                    state_nxt = GRANT;
                    grant_nxt = enc_gnt;
                    last_nxt  = enc_gnt;
                end
            end
            GRANT: begin
                if (!owner_cyc) begin
                    state_nxt = IDLE;
                    grant_nxt = '0;
                end
            end
            default: begin
                state_nxt = IDLE;
                grant_nxt = '0;
            end
        endcase
    end

    // State, grant, round-robin pointer and watchdog registers.
    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) begin
            state   <= IDLE;
            grant_o <= '0;
            last    <= LAST_RST;
            wd_cnt  <= '0;
        end else begin
            state   <= state_nxt;
            grant_o <= grant_nxt;
            last    <= last_nxt;
            wd_cnt  <= wd_cnt_nxt;
        end
    end

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Bench for wb_rr_arbiter: batches of masters request together, a queue-based
// model predicts grant order and per-transfer responses, and a negedge monitor
// checks every grant and every ack/err the arbiter presents.
module tb_wb_rr_arbiter;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int TO = 4;

  // kind: 0 ack, 1 slave err, 2 slave silent (watchdog), 3 ack+err together
  typedef struct {
    int          id;
    bit          we;
    logic [31:0] adr;
    logic [31:0] wdat;
    logic [31:0] rdat;
    logic [3:0]  sel;
    int          kind;
    int          lat;
  } xfer_t;

  typedef struct {
    int id;
    bit first;
  } gnt_exp_t;

  logic            clk;
  logic            rstn_i;
  logic [N-1:0]    m_cyc_i, m_stb_i, m_we_i;
  logic [N*AW-1:0] m_adr_i;
  logic [N*DW-1:0] m_dat_i;
  logic [N*SW-1:0] m_sel_i;
  logic [DW-1:0]   m_dat_o;
  logic [N-1:0]    m_ack_o, m_err_o, grant_o;
  logic            s_cyc_o, s_stb_o, s_we_o;
  logic [AW-1:0]   s_adr_o;
  logic [DW-1:0]   s_dat_o;
  logic [SW-1:0]   s_sel_o;
  logic [DW-1:0]   s_dat_i;
  logic            s_ack_i, s_err_i;
  logic            dbg_state;

  wb_rr_arbiter #(.N_MASTER(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk       (clk),
    .rstn_i    (rstn_i),
    .m_cyc_i   (m_cyc_i),
    .m_stb_i   (m_stb_i),
    .m_we_i    (m_we_i),
    .m_adr_i   (m_adr_i),
    .m_dat_i   (m_dat_i),
    .m_sel_i   (m_sel_i),
    .m_dat_o   (m_dat_o),
    .m_ack_o   (m_ack_o),
    .m_err_o   (m_err_o),
    .s_cyc_o   (s_cyc_o),
    .s_stb_o   (s_stb_o),
    .s_we_o    (s_we_o),
    .s_adr_o   (s_adr_o),
    .s_dat_o   (s_dat_o),
    .s_sel_o   (s_sel_o),
    .s_dat_i   (s_dat_i),
    .s_ack_i   (s_ack_i),
    .s_err_i   (s_err_i),
    .grant_o   (grant_o),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- bench state ----------------
  xfer_t        plan [N][3];
  int           nx [N];
  int           xi [N];
  bit           busy [N];
  bit           resp_seen [N];
  xfer_t        exp_q [$];
  gnt_exp_t     gexp_q [$];
  int           model_last;
  int           cyc_n;
  int           batch_start;
  int           last_drop;
  int           sl_wait;
  logic [N-1:0] prev_grant;
  int           checks;
  int           errors;
  bit           abort;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual 0x%0h required 0x%0h (cycle %0d)", name, act, req, cyc_n);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic apply_xfer(input int i);
    m_we_i[i]              = plan[i][xi[i]].we;
    m_adr_i[i*AW +: AW]    = plan[i][xi[i]].adr;
    m_dat_i[i*DW +: DW]    = plan[i][xi[i]].wdat;
    m_sel_i[i*SW +: SW]    = plan[i][xi[i]].sel;
    m_stb_i[i]             = 1'b1;
  endtask

  task automatic park_master(input int i);
    m_cyc_i[i]           = 1'b0;
    m_stb_i[i]           = 1'b0;
    m_we_i[i]            = 1'($urandom_range(0, 1));
    m_adr_i[i*AW +: AW]  = $urandom;
    m_dat_i[i*DW +: DW]  = $urandom;
    m_sel_i[i*SW +: SW]  = 4'($urandom_range(0, 15));
  endtask

  task automatic plan_set(input int i, input int t, input bit we, input logic [31:0] adr,
                          input logic [31:0] wdat, input logic [31:0] rdat,
                          input int kind, input int lat);
    plan[i][t].id   = i;
    plan[i][t].we   = we;
    plan[i][t].adr  = adr;
    plan[i][t].wdat = wdat;
    plan[i][t].rdat = rdat;
    plan[i][t].sel  = 4'hF;
    plan[i][t].kind = kind;
    plan[i][t].lat  = lat;
  endtask

  task automatic plan_rand(input int i);
    int r;
    nx[i] = $urandom_range(1, 3);
    for (int t = 0; t < 3; t++) begin
      r = $urandom_range(0, 9);
      plan_set(i, t, 1'($urandom_range(0, 1)), $urandom, $urandom, $urandom,
               (r < 6) ? 0 : (r == 6) ? 1 : (r == 7) ? 3 : 2, $urandom_range(1, TO));
      plan[i][t].sel = 4'($urandom_range(1, 15));
    end
  endtask

  // One clock: masters react to responses seen last cycle, slave answers.
  task automatic step();
    @(posedge clk);
    cyc_n++;
    #1;
    if (rstn_i) begin
      for (int i = 0; i < N; i++) begin
        if (busy[i] && resp_seen[i]) begin
          resp_seen[i] = 1'b0;
          xi[i]++;
          if (xi[i] >= nx[i]) begin
            busy[i]   = 1'b0;
            park_master(i);
            last_drop = cyc_n;
          end else begin
            apply_xfer(i);
          end
        end
      end
    end
    s_ack_i = 1'b0;
    s_err_i = 1'b0;
    s_dat_i = $urandom;
    if (rstn_i && exp_q.size() > 0 && exp_q[0].kind != 2 && sl_wait == exp_q[0].lat) begin
      s_ack_i = (exp_q[0].kind == 0 || exp_q[0].kind == 3);
      s_err_i = (exp_q[0].kind == 1 || exp_q[0].kind == 3);
      if (exp_q[0].kind == 0) s_dat_i = exp_q[0].rdat;
    end
  endtask

  // Reference model: every member of the batch holds cyc until done, so owners
  // follow one sweep of the ring starting after the previous winner.
  task automatic start_batch(input logic [N-1:0] set);
    bit       first;
    int       id;
    int       win;
    gnt_exp_t g;
    first = 1'b1;
    win   = model_last;
    for (int k = 1; k <= N; k++) begin
      id = (model_last + k) % N;
      if (set[id]) begin
        g.id    = id;
        g.first = first;
        gexp_q.push_back(g);
        first = 1'b0;
        for (int t = 0; t < nx[id]; t++) exp_q.push_back(plan[id][t]);
        win = id;
      end
    end
    model_last = win;
    for (int i = 0; i < N; i++) begin
      if (set[i]) begin
        xi[i]        = 0;
        busy[i]      = 1'b1;
        resp_seen[i] = 1'b0;
        m_cyc_i[i]   = 1'b1;
        apply_xfer(i);
      end
    end
    batch_start = cyc_n;
  endtask

  function automatic bit any_busy();
    bit b;
    b = 1'b0;
    for (int i = 0; i < N; i++) b |= busy[i];
    return b;
  endfunction

  task automatic wait_batch();
    int n;
    n = 0;
    while (any_busy() && n < 300) begin
      step();
      n++;
    end
    if (any_busy()) begin
      errors++;
      $display("FAIL batch_timeout: masters still busy after %0d cycles, required idle", n);
      abort = 1'b1;
    end
    repeat (3) step();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_grant"}, 64'(grant_o), 64'(0));
    chk({tag, "_s_cyc"}, 64'(s_cyc_o), 64'(0));
    chk({tag, "_s_stb"}, 64'(s_stb_o), 64'(0));
    chk({tag, "_s_we"},  64'(s_we_o),  64'(0));
    chk({tag, "_s_adr"}, 64'(s_adr_o), 64'(0));
    chk({tag, "_s_dat"}, 64'(s_dat_o), 64'(0));
    chk({tag, "_s_sel"}, 64'(s_sel_o), 64'(0));
    chk({tag, "_m_ack"}, 64'(m_ack_o), 64'(0));
    chk({tag, "_m_err"}, 64'(m_err_o), 64'(0));
    chk({tag, "_m_dat"}, 64'(m_dat_o), 64'(s_dat_i));
    chk({tag, "_state"}, 64'(dbg_state), 64'(0));
  endtask

  // ---------------- scoreboard monitor ----------------
  initial begin : monitor
    gnt_exp_t g;
    xfer_t    e;
    bit       exp_ack, exp_err;
    forever begin
      @(negedge clk);
      if (!rstn_i) begin
        sl_wait    = 0;
        prev_grant = '0;
      end else begin
        if (grant_o != '0 && grant_o != prev_grant) begin
          if (prev_grant != '0) begin
            errors++;
            $display("FAIL grant_switch: actual 0x%0h after 0x%0h, required an idle cycle", grant_o, prev_grant);
          end
          if (gexp_q.size() == 0) begin
            errors++;
            $display("FAIL grant_unexpected: actual 0x%0h required no grant", grant_o);
          end else begin
            g = gexp_q.pop_front();
            chk("grant_id", 64'(grant_o), 64'(1) << g.id);
            chk("grant_cycle", 64'(cyc_n), 64'(g.first ? batch_start + 1 : last_drop + 2));
          end
        end
        prev_grant = grant_o;

        if ((m_ack_o | m_err_o) != '0) begin
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL resp_unexpected: actual ack 0x%0h err 0x%0h required none", m_ack_o, m_err_o);
          end else begin
            e       = exp_q.pop_front();
            exp_ack = (e.kind == 0 || e.kind == 3);
            exp_err = (e.kind != 0);
            chk("resp_master", 64'(m_ack_o | m_err_o), 64'(1) << e.id);
            chk("resp_ack", 64'(|m_ack_o), 64'(exp_ack));
            chk("resp_err", 64'(|m_err_o), 64'(exp_err));
            chk("resp_stb", 64'(s_stb_o), 64'(e.kind != 2));
            chk("resp_wait", 64'(sl_wait), 64'((e.kind == 2) ? TO : e.lat));
            chk("resp_adr", 64'(s_adr_o), 64'(e.adr));
            chk("resp_we", 64'(s_we_o), 64'(e.we));
            if (e.we) begin
              chk("resp_wdat", 64'(s_dat_o), 64'(e.wdat));
              chk("resp_sel", 64'(s_sel_o), 64'(e.sel));
            end else if (e.kind == 0) begin
              chk("resp_rdat", 64'(m_dat_o), 64'(e.rdat));
            end
            resp_seen[e.id] = 1'b1;
          end
        end

        if (s_cyc_o && s_stb_o && !s_ack_i && !s_err_i) sl_wait++;
        else sl_wait = 0;
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin : stimulus
    checks     = 0;
    errors     = 0;
    abort      = 1'b0;
    cyc_n      = 0;
    sl_wait    = 0;
    model_last = N - 1;
    batch_start = 0;
    last_drop  = 0;
    prev_grant = '0;
    rstn_i     = 1'b0;
    s_ack_i    = 1'b0;
    s_err_i    = 1'b0;
    s_dat_i    = 32'hA5A5_0F0F;
    m_cyc_i = '0; m_stb_i = '0; m_we_i = '0; m_adr_i = '0; m_dat_i = '0; m_sel_i = '0;
    for (int i = 0; i < N; i++) begin
      busy[i] = 1'b0; resp_seen[i] = 1'b0; xi[i] = 0; nx[i] = 1;
    end

    repeat (3) step();
    check_reset_outputs("rst");
    rstn_i = 1'b1;
    for (int i = 0; i < N; i++) park_master(i);
    repeat (2) step();

    // Contention: all four request at once, one acked read each.
    for (int i = 0; i < N; i++) begin
      nx[i] = 1;
      plan_set(i, 0, 1'b0, 32'h1000 + 32'(i), 32'h0, 32'hC0DE_0000 + 32'(i), 0, 1);
    end
    start_batch(4'b1111);
    wait_batch();

    // Lone m0, leaving the pointer on m0.
    if (!abort) begin
      nx[0] = 1;
      plan_set(0, 0, 1'b1, 32'h2000, 32'h1111_2222, 32'h0, 0, 2);
      start_batch(4'b0001);
      wait_batch();
    end

    // Bus lock: m1 owns three writes under one cyc while m0 waits.
    if (!abort) begin
      nx[1] = 3;
      plan_set(1, 0, 1'b1, 32'h3000, 32'hAAAA_0001, 32'h0, 0, 1);
      plan_set(1, 1, 1'b1, 32'h3004, 32'hAAAA_0002, 32'h0, 0, 2);
      plan_set(1, 2, 1'b1, 32'h3008, 32'hAAAA_0003, 32'h0, 0, 1);
      nx[0] = 1;
      plan_set(0, 0, 1'b0, 32'h4000, 32'h0, 32'h5555_6666, 0, 1);
      start_batch(4'b0011);
      wait_batch();
    end

    // Single request: m2 reads 0x100.
    if (!abort) begin
      nx[2] = 1;
      plan_set(2, 0, 1'b0, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 0, 1);
      start_batch(4'b0100);
      wait_batch();
    end

    // Watchdog: slave never answers m3.
    if (!abort) begin
      nx[3] = 1;
      plan_set(3, 0, 1'b0, 32'h5000, 32'h0, 32'h0, 2, 1);
      start_batch(4'b1000);
      wait_batch();
    end

    // Ack arrives in the expiry cycle; slave err; ack and err together.
    if (!abort) begin
      nx[3] = 3;
      plan_set(3, 0, 1'b0, 32'h6000, 32'h0, 32'h7777_8888, 0, TO);
      plan_set(3, 1, 1'b1, 32'h6004, 32'h9999_0000, 32'h0, 1, 2);
      plan_set(3, 2, 1'b0, 32'h6008, 32'h0, 32'h0, 3, 1);
      start_batch(4'b1000);
      wait_batch();
    end

    // Randomized batches.
    for (int b = 0; b < 25 && !abort; b++) begin
      logic [N-1:0] set;
      set = 4'($urandom_range(1, 15));
      for (int i = 0; i < N; i++) plan_rand(i);
      start_batch(set);
      wait_batch();
    end

    // Reset while m1 is granted with a strobe pending.
    if (!abort) begin
      nx[1] = 1;
      plan_set(1, 0, 1'b1, 32'h7000, 32'hFEED_F00D, 32'h0, 2, 1);
      start_batch(4'b0010);
      repeat (3) step();
      chk("pre_rst_s_cyc", 64'(s_cyc_o), 64'(1));
      #2;
      rstn_i = 1'b0;
      #1;
      check_reset_outputs("midrst");
      exp_q.delete();
      gexp_q.delete();
      for (int i = 0; i < N; i++) begin
        busy[i] = 1'b0; resp_seen[i] = 1'b0; park_master(i);
      end
      model_last = N - 1;
      repeat (2) step();
      rstn_i = 1'b1;
      repeat (2) step();
      nx[0] = 1;
      plan_set(0, 0, 1'b0, 32'h8000, 32'h0, 32'h0123_4567, 0, 1);
      nx[1] = 1;
      plan_set(1, 0, 1'b1, 32'h8004, 32'h89AB_CDEF, 32'h0, 0, 1);
      start_batch(4'b0011);
      wait_batch();
    end

    chk("exp_q_drained", 64'(exp_q.size()), 64'(0));
    chk("gexp_q_drained", 64'(gexp_q.size()), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
